// File: rtl/huffman_decoder_pkg.sv
// Shared types and constants for the Huffman decode path: code-table entry
// layout, FSM state encodings and the length-clipping helper.
package huffman_decoder_pkg;

    localparam int CHAR_W       = 4;   // decoded character width
    localparam int MAX_LEN      = 7;   // longest legal code in bits
    localparam int LEN_W        = 3;   // $clog2(MAX_LEN+1)
    localparam int DEF_IP_WIDTH = 8;   // default number of table entries

    // FSM encodings kept as plain constants so legacy tools can read them.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;

    // One code-table entry: character, right-aligned code, code length.
    typedef struct packed {
        logic [CHAR_W-1:0]  chr;
        logic [MAX_LEN-1:0] code;
        logic [LEN_W-1:0]   len;
    } entry_t;

    // Lengths above MAX_LEN are clamped so an oversized entry still behaves
    // as a MAX_LEN code instead of becoming unreachable.
    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] len);
        if (int'(len) > MAX_LEN) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Table-load, serial-bit and decoded-output signals of the Huffman decoder.
// The master drives table entries and bits; the slave is the decoder.
interface huffman_decoder_if;
    import huffman_decoder_pkg::*;

    logic                in_valid;
    logic [CHAR_W-1:0]   in_character;
    logic [MAX_LEN-1:0]  in_code;
    logic [LEN_W-1:0]    in_len;
    logic                bit_valid;
    logic                bit_in;
    logic                bit_last;
    logic                ready;
    logic                out_valid;
    logic [CHAR_W-1:0]   out_character;
    logic                out_err;
    logic                out_done;

    modport master (
        output in_valid, in_character, in_code, in_len,
        output bit_valid, bit_in, bit_last,
        input  ready, out_valid, out_character, out_err, out_done
    );

    modport slave (
        input  in_valid, in_character, in_code, in_len,
        input  bit_valid, bit_in, bit_last,
        output ready, out_valid, out_character, out_err, out_done
    );

endinterface

// File: rtl/huffman_match.sv
// Combinational code lookup: finds the table entry whose length equals the
// number of accumulated bits and whose code equals those bits. When a
// malformed table holds duplicates, the lowest index wins.
module huffman_match
    import huffman_decoder_pkg::*;
#(
    parameter int N = DEF_IP_WIDTH
) (
    input  entry_t [N-1:0]      tbl,
    input  logic [MAX_LEN-1:0]  acc_next,
    input  logic [LEN_W-1:0]    cnt_next,
    output logic                hit,
    output logic [CHAR_W-1:0]   chr
);

    logic [MAX_LEN-1:0] mask;

    // Build a mask covering the low cnt_next bits of the accumulator.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and a latch is never inferred.
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(cnt_next));
        end
    end

    // Scan from the top index down so the lowest matching index is the last writer.
    always_comb begin
        hit = 1'b0;
        chr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((tbl[i].len != '0) && (tbl[i].len == cnt_next) &&
                (((tbl[i].code ^ acc_next) & mask) == '0)) begin
                hit = 1'b1;
                chr = tbl[i].chr;
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Sequential Huffman bitstream decoder: loads IP_WIDTH code-table entries,
// then shifts in one bit per cycle and emits a character whenever the
// accumulated bits form a complete code. All outputs are registered, one
// cycle after the bit that produced them.
module huffman_decoder
    import huffman_decoder_pkg::*;
#(
    parameter int IP_WIDTH = DEF_IP_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    huffman_decoder_if.slave  bus
);

    localparam int IDX_W = (IP_WIDTH > 1) ? $clog2(IP_WIDTH) : 1;

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    entry_t [IP_WIDTH-1:0]    tbl;
    logic [MAX_LEN-2:0]       acc;
    logic [LEN_W-1:0]         cnt;

    logic                     valid_q;
    logic [CHAR_W-1:0]        char_q;
    logic                     err_q;
    logic                     done_q;

    logic [MAX_LEN-1:0]       acc_next;
    logic [LEN_W-1:0]         cnt_next;
    logic                     full;
    logic                     load_en;
    logic                     last_idx;
    logic                     hit;
    logic [CHAR_W-1:0]        hit_char;
    entry_t                   new_entry;

    assign acc_next  = {acc, bus.bit_in};
    assign cnt_next  = cnt + LEN_W'(1);
    assign full      = (cnt_next == LEN_W'(MAX_LEN));
    assign load_en   = bus.in_valid && ((state == ST_IDLE) || (state == ST_LOAD));
    assign last_idx  = (idx == IDX_W'(IP_WIDTH - 1));
    assign new_entry = '{chr: bus.in_character, code: bus.in_code, len: clip_len(bus.in_len)};

    huffman_match #(.N(IP_WIDTH)) u_match (
        .tbl      (tbl),
        .acc_next (acc_next),
        .cnt_next (cnt_next),
        .hit      (hit),
        .chr      (hit_char)
    );

    // Code table: written one entry per in_valid cycle while loading, frozen while decoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the table is reset, not merely overwritten, so a reset mid-load leaves only zero-length entries that can never match.
            tbl <= '0;
        end else if (load_en) begin
            tbl[idx] <= new_entry;
        end
    end

    // Load sequencing, bit accumulation and registered decode results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
            state   <= ST_IDLE;
            idx     <= '0;
            acc     <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            char_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            char_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (last_idx) begin
                            state <= ST_DECODE;
                            idx   <= '0;
                        end else begin
                            state <= ST_LOAD;
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DECODE: begin
                    if (bus.bit_valid) begin
                        if (hit) begin
                            valid_q <= 1'b1;
                            char_q  <= hit_char;
                        end else if (full || bus.bit_last) begin
                            // Either no code can be this long, or the stream ended mid-code.
                            err_q <= 1'b1;
                        end
                        if (hit || full || bus.bit_last) begin
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            acc <= acc_next[MAX_LEN-2:0];
                            cnt <= cnt_next;
                        end
                        if (bus.bit_last) begin
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready         = (state == ST_DECODE);
    assign bus.out_valid     = valid_q;
    assign bus.out_character = char_q;
    assign bus.out_err       = err_q;
    assign bus.out_done      = done_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder. A behavioural model tracks the
// loaded table and the bits received since the last code boundary as plain
// integers and predicts every output each cycle; directed sessions add
// literal expectations on the decoded character sequence.
module tb_huffman_decoder;

    localparam int IPW  = 8;
    localparam int MAXL = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    huffman_decoder_if bus ();

    huffman_decoder #(.IP_WIDTH(IPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Table contents the stimulus will load.
    int t_chr [IPW];
    int t_code[IPW];
    int t_len [IPW];

    // Behavioural model state.
    int m_chr [IPW];
    int m_code[IPW];
    int m_len [IPW];
    int m_mode;          // 0 idle, 1 loading, 2 decoding
    int m_loaded;
    int m_bits;
    int m_nb;

    logic       exp_ready, exp_valid, exp_err, exp_done;
    logic [3:0] exp_char;

    int dut_chars[$];
    int mdl_chars[$];
    int dut_errs, dut_dones;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_loaded = 0; m_bits = 0; m_nb = 0;
        for (int i = 0; i < IPW; i++) begin
            m_chr[i] = 0; m_code[i] = 0; m_len[i] = 0;
        end
        exp_ready = 0; exp_valid = 0; exp_err = 0; exp_done = 0; exp_char = 0;
    endtask

    task automatic model_step();
        int found;
        exp_valid = 0; exp_err = 0; exp_done = 0; exp_char = 0;
        if (m_mode != 2) begin
            if (bus.in_valid) begin
                m_chr[m_loaded]  = int'(bus.in_character);
                m_code[m_loaded] = int'(bus.in_code);
                m_len[m_loaded]  = int'(bus.in_len);
                m_loaded++;
                if (m_loaded == IPW) begin
                    m_mode = 2; m_loaded = 0;
                end else begin
                    m_mode = 1;
                end
            end
        end else if (bus.bit_valid) begin
            m_bits = m_bits * 2 + int'(bus.bit_in);
            m_nb++;
            found = -1;
            for (int i = 0; i < IPW; i++) begin
                if (found < 0 && m_len[i] == m_nb && (m_code[i] % (1 << m_nb)) == m_bits)
                    found = i;
            end
            if (found >= 0) begin
                exp_valid = 1; exp_char = 4'(m_chr[found]);
                mdl_chars.push_back(m_chr[found]);
                m_bits = 0; m_nb = 0;
            end else if (m_nb == MAXL) begin
                exp_err = 1; m_bits = 0; m_nb = 0;
            end
            if (bus.bit_last) begin
                if (found < 0 && m_nb > 0) exp_err = 1;
                exp_done = 1; m_bits = 0; m_nb = 0; m_mode = 0;
            end
        end
        exp_ready = (m_mode == 2);
    endtask

    // Model advances on each active edge while out of reset.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) model_step();
        end
    end

    // Compare process: every output every cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("ready",         32'(bus.ready),         32'(exp_ready));
            check("out_valid",     32'(bus.out_valid),     32'(exp_valid));
            check("out_character", 32'(bus.out_character), 32'(exp_char));
            check("out_err",       32'(bus.out_err),       32'(exp_err));
            check("out_done",      32'(bus.out_done),      32'(exp_done));
            if (bus.out_valid) dut_chars.push_back(int'(bus.out_character));
            if (bus.out_err)   dut_errs++;
            if (bus.out_done)  dut_dones++;
        end
    end

    task automatic clear_records();
        dut_chars.delete(); mdl_chars.delete();
        dut_errs = 0; dut_dones = 0;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < IPW; i++) begin
            t_chr[i] = 0; t_code[i] = 0; t_len[i] = 0;
        end
    endtask

    task automatic set_entry(input int k, input int chr, input int code, input int len);
        t_chr[k] = chr; t_code[k] = code; t_len[k] = len;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 0; bus.bit_valid = 0; bus.bit_in = 0; bus.bit_last = 0;
        end
    endtask

    // Loads the staged table; one idle cycle is inserted before entry gap_at,
    // and stray bit strobes are driven throughout (they must be ignored).
    task automatic load_table(input int gap_at);
        for (int k = 0; k < IPW; k++) begin
            if (k == gap_at) begin
                @(negedge clk);
                bus.in_valid = 0; bus.bit_valid = 1; bus.bit_in = 1;
            end
            @(negedge clk);
            bus.in_valid     = 1;
            bus.in_character = 4'(t_chr[k]);
            bus.in_code      = 7'(t_code[k]);
            bus.in_len       = 3'(t_len[k]);
            bus.bit_valid    = 1;
            bus.bit_in       = 0;
        end
        idle(1);
    endtask

    task automatic send_bit(input logic b, input logic last);
        @(negedge clk);
        bus.in_valid = 0; bus.bit_valid = 1; bus.bit_in = b; bus.bit_last = last;
    endtask

    task automatic abcd_table();
        clear_tbl();
        set_entry(0, 1, 7'b0000000, 1);
        set_entry(1, 2, 7'b0000010, 2);
        set_entry(2, 3, 7'b0000110, 3);
        set_entry(3, 4, 7'b0000111, 3);
    endtask

    initial begin
        logic [8:0] s1;
        bus.in_valid = 0; bus.in_character = 0; bus.in_code = 0; bus.in_len = 0;
        bus.bit_valid = 0; bus.bit_in = 0; bus.bit_last = 0;
        model_reset();
        clear_records();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        rst = 0;

        // Session 1: four codes decoded back to back, done with the last.
        abcd_table();
        load_table(3);
        clear_records();
        s1 = 9'b010110111;
        for (int i = 8; i >= 0; i--) send_bit(s1[i], i == 0);
        idle(3);
        check("s1_count", 32'(dut_chars.size()), 4);
        check("s1_c0", 32'(dut_chars[0]), 1);
        check("s1_c1", 32'(dut_chars[1]), 2);
        check("s1_c2", 32'(dut_chars[2]), 3);
        check("s1_c3", 32'(dut_chars[3]), 4);
        check("s1_model_c3", 32'(mdl_chars[3]), 4);
        check("s1_done", 32'(dut_dones), 1);

        // Session 2: truncated code at end of stream.
        load_table(-1);
        clear_records();
        send_bit(1, 0);
        send_bit(1, 1);
        idle(2);
        check("s2_err", 32'(dut_errs), 1);
        check("s2_done", 32'(dut_dones), 1);
        check("s2_chars", 32'(dut_chars.size()), 0);
        check("s2_ready", 32'(bus.ready), 0);

        // Session 3: single 7-bit code; seven zeros overflow, seven ones match.
        clear_tbl();
        set_entry(0, 5, 7'b1111111, 7);
        load_table(-1);
        clear_records();
        for (int i = 0; i < 7; i++) send_bit(0, 0);
        idle(2);
        check("s3_err", 32'(dut_errs), 1);
        check("s3_no_char", 32'(dut_chars.size()), 0);
        check("s3_ready_mid", 32'(bus.ready), 1);
        for (int i = 0; i < 7; i++) send_bit(1, i == 6);
        idle(2);
        check("s3_char", 32'(dut_chars[0]), 5);
        check("s3_model_char", 32'(mdl_chars[0]), 5);
        check("s3_done", 32'(dut_dones), 1);

        // Session 4: gapped bits of "110", with ignored in_valid in the gaps.
        abcd_table();
        load_table(-1);
        clear_records();
        send_bit(1, 0);
        @(negedge clk); bus.bit_valid = 0; bus.in_valid = 1;
        send_bit(1, 0);
        @(negedge clk); bus.bit_valid = 0; bus.in_valid = 1;
        @(negedge clk); bus.bit_valid = 0; bus.in_valid = 0;
        send_bit(0, 1);
        idle(2);
        check("s4_count", 32'(dut_chars.size()), 1);
        check("s4_char", 32'(dut_chars[0]), 3);
        check("s4_done", 32'(dut_dones), 1);

        // Session 5: asynchronous reset mid-decode, then bits without reload.
        load_table(-1);
        clear_records();
        send_bit(1, 0);
        send_bit(1, 0);
        @(posedge clk);
        #1;
        check("s5_ready_pre", 32'(bus.ready), 1);
        #1;
        rst = 1;
        model_reset();
        #1;
        check("s5_async_ready", 32'(bus.ready), 0);
        check("s5_async_valid", 32'(bus.out_valid), 0);
        check("s5_async_err", 32'(bus.out_err), 0);
        check("s5_async_done", 32'(bus.out_done), 0);
        @(negedge clk);
        rst = 0;
        send_bit(0, 0);
        send_bit(1, 0);
        send_bit(0, 1);
        idle(2);
        check("s5_ignored_chars", 32'(dut_chars.size()), 0);
        check("s5_ignored_done", 32'(dut_dones), 0);

        // Session 6: duplicate entries, lowest index wins.
        clear_tbl();
        set_entry(0, 7, 7'b0000000, 1);
        set_entry(5, 9, 7'b0000000, 1);
        load_table(-1);
        clear_records();
        send_bit(0, 1);
        idle(2);
        check("s6_char", 32'(dut_chars[0]), 7);
        check("s6_model_char", 32'(mdl_chars[0]), 7);
        check("s6_done", 32'(dut_dones), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Sequential Huffman bitstream decoder. It is the consumer side of the weight-sort / code-build path: the encoder side sorts characters by weight and assigns prefix codes, and this block turns the serialized codes back into characters.
- Operation: load a code table of IP_WIDTH entries, then accept one bit per cycle and emit a 4-bit character whenever the accumulated bits match a table entry.
- Sits downstream of the code-table builder and the serial bit channel in the Huffman datapath.

Parameters:
IP_WIDTH, 8, number of table entries (characters) loaded per session
MAX_LEN, 7, maximum code length in bits (IP_WIDTH-1 for a full Huffman tree)
LEN_W, 3, width of code-length field, $clog2(MAX_LEN+1)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  table-entry strobe, IP_WIDTH consecutive cycles
in_character  input  4  character of current entry
in_code  input  MAX_LEN  code bits, right-aligned; first transmitted bit is in_code[in_len-1]
in_len  input  LEN_W  code length; 0 = unused entry, never matches
bit_valid  input  1  serial bit strobe
bit_in  input  1  serial code bit
bit_last  input  1  qualifies the final bit of the stream (sampled with bit_valid)
ready  output  1  high in DECODE state only
out_valid  output  1  one-cycle pulse, decoded character valid
out_character  output  4  decoded character, 0 when out_valid low
out_err  output  1  one-cycle pulse, invalid or truncated code
out_done  output  1  one-cycle pulse, stream finished

Behaviour:
- Reset (async, any state): FSM to IDLE; table lengths cleared to 0; accumulator and bit count cleared. All outputs 0: ready, out_valid, out_character, out_err, out_done.
- States:
  - IDLE -> LOAD on in_valid; that cycle's entry is written as entry 0.
  - LOAD: writes entry k on the k-th in_valid cycle; after entry IP_WIDTH-1 -> DECODE. in_valid low in LOAD holds the index, no write.
  - DECODE: ready=1; each cycle with bit_valid processes one bit.
  - DECODE -> IDLE after the bit_last bit is processed.
- Bit processing:
  - acc_next = {acc[MAX_LEN-2:0], bit_in}; cnt_next = cnt+1.
  - Match: the entry with in_len == cnt_next and code[cnt_next-1:0] == acc_next[cnt_next-1:0].
  - Multiple matches (malformed table): lowest index wins.
  - On match: next cycle out_valid=1, out_character=entry character; acc and cnt cleared.
  - No match and cnt_next == MAX_LEN: next cycle out_err=1; acc and cnt cleared; decoding continues with the following bit.
  - No match and cnt_next < MAX_LEN: keep accumulating; no output.
- Latency: exactly 1 cycle from the accepted bit to out_valid / out_err / out_done. Outputs are registered.
- bit_last:
  - Matched: out_valid and out_done assert in the same cycle.
  - Partial code left (no match, cnt_next > 0): out_err and out_done assert together.
  - In both cases acc/cnt cleared and FSM -> IDLE.
- bit_valid outside DECODE is ignored. in_valid in DECODE is ignored (table is frozen).
- Table persists after IDLE until the next load overwrites it; a new session always reloads all IP_WIDTH entries.
- Reset mid-LOAD or mid-DECODE: partial table discarded, no out_done emitted.
- A single-entry table with in_len=1 is legal. An entry with in_len > MAX_LEN is clipped to MAX_LEN.

Decomposition:
- Shared package: CHAR_W=4, MAX_LEN, LEN_W, FSM state enum {IDLE, LOAD, DECODE}, table-entry struct {char, code, len}.
- One sub-module: huffman_match. Purely combinational; inputs are table, acc_next, cnt_next; outputs are hit and char via lowest-index priority. Reusable by an encoder-side checker.

Test Plan:
- Load A=1:"0"/1, B=2:"10"/2, C=3:"110"/3, D=4:"111"/3, entries 4-7 len 0. Stream 0,1,0,1,1,0,1,1,1(last). Expect out_character 1,2,3,4, each 1 cycle after its final bit; out_done with the 4.
- Same table, stream 1,1 with bit_last on the second bit. Expect out_err=1 and out_done=1 together, no out_valid, FSM in IDLE, ready=0.
- Table with code "1111111"/7 only (others len 0), stream of 7 zeros. Expect out_err pulse after the 7th bit. Then stream 1 x7 (last on 7th): expect out_valid char of that entry plus out_done.
- Gapped bits: bit_valid low between bits of "110". Expect char 3 only after the third valid bit; no output during gaps.
- Assert rst mid-DECODE after bits 1,1. Expect all outputs 0 immediately (async). Bit stream after reset without reload: ignored, ready=0.
- Duplicate entries 0 and 5 both "0"/1 with chars 7 and 9. Stream 0(last): expect out_character=7 plus out_done.
